// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store unit: alignment check, byte-lane strobes and
// a two-phase addr_ok/data_ok bus handshake with a one-cycle response.
module lsu_mem_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [5:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  input  logic                flush,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                resp_valid,
  output logic [31:0]         resp_data,
  output logic                resp_exc,
  output logic                resp_exc_store,
  output logic [ADDR_W-1:0]   resp_badvaddr,
  output logic                stall
);
  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t           state;
  logic [5:0]       op_q;
  logic [OFF_W-1:0] off_q;
  logic             killed;

  logic             is_b, is_h, is_w, is_st, is_mem, mis;
  logic [OFF_W-1:0] off;
  logic [LANES-1:0] base, wstrb_n;
  logic [DATA_W-1:0] wdata_n;
  logic [31:0]      word, sh, ld;

  always_comb begin
    is_b  = 1'b0;
    is_h  = 1'b0;
    is_w  = 1'b0;
    is_st = 1'b0;
    case (req_op)
      OP_LB, OP_LBU: is_b = 1'b1;
      OP_LH, OP_LHU: is_h = 1'b1;
      OP_LW:         is_w = 1'b1;
      OP_SB: begin is_b = 1'b1; is_st = 1'b1; end
      OP_SH: begin is_h = 1'b1; is_st = 1'b1; end
      OP_SW: begin is_w = 1'b1; is_st = 1'b1; end
      default: ;
    endcase
  end

  assign is_mem = is_b | is_h | is_w;
  assign mis    = (is_h & req_addr[0]) | (is_w & |req_addr[1:0]);
  assign off    = req_addr[OFF_W-1:0];

  always_comb begin
    base = '0;
    if (is_b) base[0]   = 1'b1;
    if (is_h) base[1:0] = 2'b11;
    if (is_w) base[3:0] = 4'hf;
  end

  assign wstrb_n = is_st ? (base << off) : '0;

  always_comb begin
    if (is_b)      wdata_n = {LANES{req_wdata[7:0]}};
    else if (is_h) wdata_n = {(LANES/2){req_wdata[15:0]}};
    else           wdata_n = {(LANES/4){req_wdata}};
  end

  // Pick the 32-bit word holding the access, then the lane inside it.
  generate
    if (LANES > 4) begin : g_wsel
      assign word = bus_rdata[{off_q[OFF_W-1:2], 5'b0} +: 32];
    end else begin : g_wfix
      assign word = bus_rdata[31:0];
    end
  endgenerate

  assign sh = word >> {off_q[1:0], 3'b000};

  always_comb begin
    case (op_q)
      OP_LB:   ld = {{24{sh[7]}}, sh[7:0]};
      OP_LBU:  ld = {24'b0, sh[7:0]};
      OP_LH:   ld = {{16{sh[15]}}, sh[15:0]};
      OP_LHU:  ld = {16'b0, sh[15:0]};
      OP_LW:   ld = sh;
      default: ld = '0;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign stall      = (state != IDLE);
  assign resp_valid = (state == RESP) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      op_q           <= '0;
      off_q          <= '0;
      killed         <= 1'b0;
      bus_req        <= 1'b0;
      bus_wr         <= 1'b0;
      bus_addr       <= '0;
      bus_wstrb      <= '0;
      bus_wdata      <= '0;
      resp_data      <= '0;
      resp_exc       <= 1'b0;
      resp_exc_store <= 1'b0;
      resp_badvaddr  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          resp_data      <= '0;
          resp_exc       <= 1'b0;
          resp_exc_store <= 1'b0;
          resp_badvaddr  <= '0;
          if (req_valid && !flush) begin
            op_q      <= req_op;
            off_q     <= off;
            killed    <= 1'b0;
            bus_wr    <= is_st;
            bus_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            bus_wstrb <= wstrb_n;
            bus_wdata <= wdata_n;
            if (mis) begin
              state          <= RESP;
              resp_exc       <= 1'b1;
              resp_exc_store <= is_st;
              resp_badvaddr  <= req_addr;
            end else if (!is_mem) begin
              state <= RESP;
            end else begin
              state   <= REQ;
              bus_req <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            if (bus_data_ok) begin
              resp_data <= ld;
              state     <= flush ? IDLE : RESP;
            end else begin
              state  <= WAIT;
              killed <= flush;
            end
          end else if (flush) begin
            bus_req <= 1'b0;
            state   <= IDLE;
          end
        end
        WAIT: begin
          // A flushed load still owns the bus until its data_ok arrives.
          if (bus_data_ok) begin
            resp_data <= ld;
            state     <= (killed || flush) ? IDLE : RESP;
          end else if (flush) begin
            killed <= 1'b1;
          end
        end
        RESP: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl (64-bit bus): random and directed
// requests, bus/response monitor compares against a byte-level model.
module tb_lsu_mem_ctrl;
  localparam logic [5:0] LB  = 6'h20;
  localparam logic [5:0] LH  = 6'h21;
  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25;
  localparam logic [5:0] SB  = 6'h28;
  localparam logic [5:0] SH  = 6'h29;
  localparam logic [5:0] SW  = 6'h2b;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, flush;
  logic [5:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [31:0] bus_addr;
  logic [7:0]  bus_wstrb;
  logic [63:0] bus_wdata, bus_rdata;
  logic        resp_valid, resp_exc, resp_exc_store, stall;
  logic [31:0] resp_data, resp_badvaddr;

  lsu_mem_ctrl #(.DATA_W(64), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .flush(flush),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_exc(resp_exc), .resp_exc_store(resp_exc_store),
    .resp_badvaddr(resp_badvaddr), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [7:0]  strb;
    logic [63:0] wd;
  } bexp_t;

  typedef struct {
    logic [31:0] data;
    bit          exc;
    bit          st;
    logic [31:0] bad;
    int          lat;
  } rexp_t;

  bexp_t bq[$];
  rexp_t rq[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc = 0;

  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction

  function automatic void classify(input logic [5:0] op, output int sz,
                                   output bit st, output bit mem,
                                   output bit sg);
    sz = 1; st = 0; mem = 1; sg = 0;
    case (op)
      LB:  sg = 1;
      LBU: sz = 1;
      LH:  begin sz = 2; sg = 1; end
      LHU: sz = 2;
      LW:  sz = 4;
      SB:  st = 1;
      SH:  begin sz = 2; st = 1; end
      SW:  begin sz = 4; st = 1; end
      default: mem = 0;
    endcase
  endfunction

  // Load result from the byte view of the 64-bit read data.
  function automatic logic [31:0] ld_model(logic [5:0] op, logic [31:0] a,
                                           logic [63:0] rd);
    int sz, off;
    bit st, mem, sg;
    longint v;
    classify(op, sz, st, mem, sg);
    if (!mem || st) return 32'h0;
    off = int'(a % 8);
    v = 0;
    for (int i = sz - 1; i >= 0; i--)
      v = v * 256 + longint'(rd[8*(off+i) +: 8]);
    if (sg && v >= (longint'(1) << (8*sz - 1)))
      v = v - (longint'(1) << (8*sz));
    return v[31:0];
  endfunction

  function automatic bexp_t bus_model(logic [5:0] op, logic [31:0] a,
                                      logic [31:0] wd);
    bexp_t b;
    int sz, off;
    bit st, mem, sg;
    classify(op, sz, st, mem, sg);
    off = int'(a % 8);
    b.addr = a & ~32'h7;
    b.wr = st;
    for (int i = 0; i < 8; i++) begin
      b.strb[i] = st && i >= off && i < off + sz;
      b.wd[8*i +: 8] = wd[8*(i % sz) +: 8];
    end
    return b;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (req_valid && req_ready && !flush) last_acc = cyc;
      if (bus_req && bus_addr_ok) begin
        if (bq.size() == 0) chk("unexpected_bus", 1, 0);
        else begin
          bexp_t b;
          b = bq.pop_front();
          chk("bus_addr", bus_addr, b.addr);
          chk("bus_wr", bus_wr, b.wr);
          chk("bus_wstrb", bus_wstrb, b.strb);
          if (b.wr) chk("bus_wdata", bus_wdata, b.wd);
        end
      end
      if (resp_valid) begin
        if (rq.size() == 0) chk("unexpected_resp", 1, 0);
        else begin
          rexp_t r;
          r = rq.pop_front();
          chk("resp_lat", cyc - last_acc, r.lat);
          chk("resp_data", resp_data, r.data);
          chk("resp_exc", resp_exc, r.exc);
          if (r.exc) begin
            chk("resp_exc_store", resp_exc_store, r.st);
            chk("resp_badvaddr", resp_badvaddr, r.bad);
          end
        end
      end
    end
  end

  // fl: 1 flush in REQ before addr_ok, 2 flush in WAIT, 3 flush in RESP
  task automatic do_req(input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [63:0] rd,
                        input int ad, input int dd, input int fl);
    int sz, ka, kd;
    bit st, mem, sg, mis;
    rexp_t r;
    classify(op, sz, st, mem, sg);
    mis = mem && (a % sz != 0);
    @(posedge clk); #1;
    req_valid = 1; req_op = op; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0;
    if (!mem || mis) begin
      if (fl == 3) flush = 1;
      else begin
        r = '{data: 32'h0, exc: mis, st: st, bad: a, lat: 1};
        rq.push_back(r);
      end
      chk("exc_no_bus", bus_req, 0);
      @(posedge clk); #1;
      flush = 0;
    end else if (fl == 1 && ad >= 1) begin
      chk("flreq_bus_hi", bus_req, 1);
      flush = 1;
      @(posedge clk); #1;
      flush = 0;
      chk("flreq_bus_drop", bus_req, 0);
      chk("flreq_ready", req_ready, 1);
    end else begin
      bq.push_back(bus_model(op, a, wd));
      ka = ad + 1;
      kd = ad + 1 + dd;
      if (!(fl == 2 && dd >= 2)) begin
        r = '{data: ld_model(op, a, rd), exc: 0, st: 0, bad: 0,
              lat: ad + dd + 2};
        rq.push_back(r);
      end
      for (int k = 1; k <= kd; k++) begin
        chk("bus_req_phase", bus_req, k <= ka);
        chk("stall_busy", stall, 1);
        bus_addr_ok = (k == ka);
        bus_data_ok = (k == kd);
        bus_rdata = (k == kd) ? rd : {$urandom, $urandom};
        flush = (fl == 2 && dd >= 2 && k == ka + 1);
        @(posedge clk); #1;
        bus_addr_ok = 0; bus_data_ok = 0; flush = 0;
      end
      if (fl == 2 && dd >= 2) chk("flwait_ready", req_ready, 1);
    end
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("idle_timeout", req_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [5:0] ops[10];
    rst = 1; req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0;
    flush = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW, 6'h00, 6'h0f};
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_exc", resp_exc, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_stall", stall, 0);

    do_req(LB, 32'h1003, 32'h0, 64'h80FF_0000, 0, 0, 0);
    do_req(SH, 32'h0000_0106, 32'h0000_BEEF, 64'h0, 0, 0, 0);
    do_req(LW, 32'h2002, 32'h0, 64'h0, 0, 0, 0);
    do_req(SW, 32'h2001, 32'h1234_5678, 64'h0, 0, 0, 0);
    do_req(LHU, 32'h10, 32'h0, 64'h1234_ABCD, 3, 2, 0);
    do_req(6'h0f, 32'h40, 32'h55, 64'h0, 0, 0, 0);
    do_req(LW, 32'h84, 32'h0, 64'hCAFE_F00D_0000_0000, 1, 3, 2);
    do_req(LB, 32'h31, 32'h0, 64'h0, 2, 0, 1);
    do_req(6'h00, 32'h50, 32'h0, 64'h0, 0, 0, 3);

    @(posedge clk); #1;
    req_valid = 1; req_op = LB; req_addr = 32'h7; flush = 1;
    @(posedge clk); #1;
    chk("flidle_ready", req_ready, 1);
    chk("flidle_bus", bus_req, 0);
    req_valid = 0; flush = 0;

    bq.push_back(bus_model(LW, 32'h300, 32'h0));
    @(posedge clk); #1;
    req_valid = 1; req_op = LW; req_addr = 32'h300;
    @(posedge clk); #1;
    req_valid = 0; bus_addr_ok = 1;
    @(posedge clk); #1;
    bus_addr_ok = 0;
    chk("wait_stall", stall, 1);
    #2 rst = 1;
    #1;
    chk("arst_bus_req", bus_req, 0);
    chk("arst_bus_addr", bus_addr, 0);
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_resp_data", resp_data, 0);
    chk("arst_stall", stall, 0);
    @(posedge clk); #1;
    rst = 0;
    do_req(LW, 32'h308, 32'h0, 64'h1111_2222_3333_4444, 1, 1, 0);

    for (int n = 0; n < 60; n++) begin
      int sz, fl, ad, dd;
      bit st, mem, sg;
      logic [5:0] op;
      logic [31:0] a;
      op = ops[$urandom_range(0, 9)];
      classify(op, sz, st, mem, sg);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      ad = $urandom_range(0, 3);
      dd = $urandom_range(0, 3);
      fl = $urandom_range(0, 9);
      if (fl > 3) fl = 0;
      do_req(op, a, $urandom, {$urandom, $urandom}, ad, dd, fl);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("bus_queue_empty", bq.size(), 0);
    chk("resp_queue_empty", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Sequential successor to the combinational byte-lane selector in the MEM stage.
- Accepts one load/store request at a time from the pipeline and checks address alignment before any bus access.
- Drives a parametrised-width data bus with byte strobes and a two-phase addr_ok/data_ok handshake.
- Returns the lane-extracted, sign/zero-extended load result, or a misalignment exception, through a one-cycle response pulse.

Parameters:
- DATA_W, 32: data bus width in bits; legal values 32 and 64. LANES = DATA_W/8, OFF_W = log2(LANES).
- ADDR_W, 32: address width in bits.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  block can accept a request.
- req_op  in  6  opcode; EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP from defines.vh.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data.
- flush  in  1  kill the in-flight request (exception or branch flush).
- bus_req  out  1  bus request valid.
- bus_wr  out  1  1 = store, 0 = load.
- bus_addr  out  ADDR_W  req_addr with low OFF_W bits cleared.
- bus_wstrb  out  LANES  byte write strobes; all 0 for loads.
- bus_wdata  out  DATA_W  store data replicated across lanes.
- bus_addr_ok  in  1  bus accepted the address phase.
- bus_data_ok  in  1  bus returned read data or completed the write.
- bus_rdata  in  DATA_W  read data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  32  load result; 0 for stores and exceptions.
- resp_exc  out  1  address error.
- resp_exc_store  out  1  1 = AdES, 0 = AdEL; qualified by resp_exc.
- resp_badvaddr  out  ADDR_W  faulting address; qualified by resp_exc.
- stall  out  1  high whenever state is not IDLE; pipeline freezes on it.

Behaviour:
- Reset, asynchronous: state = IDLE. All registered outputs = 0, including bus_req, resp_valid, resp_exc and resp_data.
- States: IDLE, REQ, WAIT, RESP.
- req_ready = (state == IDLE). Accept happens when req_valid && req_ready && !flush.
- On accept, register op, addr, strobes and write data, then apply exactly one rule:
  - misaligned → RESP with resp_exc = 1;
  - non-memory op → RESP with resp_exc = 0 and resp_data = 0, no bus access;
  - otherwise → REQ.
- Misalignment rules:
  - LH, LHU, SH: addr[0] != 0.
  - LW, SW: addr[1:0] != 0.
  - Byte ops never fault.
- Byte-lane offset: off = addr[OFF_W-1:0].
- Strobes:
  - SB: bit off set.
  - SH: bits off and off+1 set.
  - SW: bits off..off+3 set.
- Write data:
  - SB: byte replicated LANES times.
  - SH: halfword replicated LANES/2 times.
  - SW: word replicated LANES/4 times.
- REQ state:
  - bus_req = 1, with bus_addr, bus_wr, bus_wstrb and bus_wdata held stable until bus_addr_ok.
  - addr_ok && data_ok in the same cycle → RESP.
  - addr_ok only → WAIT.
- WAIT state: bus_req = 0; on data_ok → RESP.
- Load data capture: on data_ok, take the byte, halfword or word at bus_rdata[off*8 +: n].
  - Sign-extend for LB, LH; zero-extend for LBU, LHU; LW passes the word unchanged.
  - Register the result into resp_data.
- RESP state: resp_valid = 1 for exactly one cycle, then IDLE. No new accept occurs in the RESP cycle.
- Minimum latency, with addr_ok and data_ok both high in the first REQ cycle:
  - accept at cycle 0, bus_req at cycle 1, resp_valid at cycle 2.
  - Misaligned or non-memory op: resp_valid at cycle 1.
- Flush:
  - In REQ without addr_ok → IDLE, no response.
  - In REQ with addr_ok, or in WAIT → mark the request killed. Stay in or enter WAIT until data_ok, which must never be dropped, then go to IDLE without resp_valid.
  - In RESP → suppress resp_valid and return to IDLE.
  - In IDLE → blocks accept.
- Bus protocol: at most one outstanding bus transaction.
- bus_data_ok outside WAIT or REQ+addr_ok: ignored.
- Reset mid-transaction: immediate return to IDLE with outputs cleared. Bus-side cleanup is the bus owner's duty.

Test Plan:
- DATA_W=32, LB addr 0x1003, bus_rdata 0x80FF_0000, addr_ok and data_ok in the first REQ cycle → resp_valid at cycle 2, resp_data = 0xFFFF_FF80.
- DATA_W=64, SH addr 0x0000_0106, wdata 0x0000_BEEF → bus_addr 0x100, wstrb 0xC0, wdata 0xBEEF replicated 4 times, bus_wr = 1.
- LW addr 0x2002 → no bus_req, resp_valid at cycle 1, resp_exc = 1, resp_exc_store = 0, badvaddr 0x2002. SW addr 0x2001 → resp_exc_store = 1.
- LHU addr 0x10 with addr_ok delayed 3 cycles and data_ok 2 cycles later, rdata 0x1234_ABCD → bus_req held 4 cycles, stall high throughout, resp_data = 0x0000_ABCD.
- Flush in WAIT → data_ok consumed, no resp_valid, req_ready high the cycle after data_ok. Flush in REQ before addr_ok → bus_req drops next cycle.
- Reset asserted in WAIT → all outputs 0 asynchronously. A new LW after reset release completes normally.
